// File: rtl/readback_snapshot_ctrl.sv
// Readback snapshot controller: toggle request/ack front end that drives the
// readback mux address, waits for the mux to settle, then latches a coherent,
// sequence-tagged A/B pair for the PS to read.
module readback_snapshot_ctrl #(
    parameter logic [31:0] DEFAULT_ADDR  = 32'd100001,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SEQ_WIDTH     = 16
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic [31:0]          ps_config_addr,
    input  logic                 ps_req_toggle,
    output logic [31:0]          rb_config_addr,
    input  logic [31:0]          rb_dataA,
    input  logic [31:0]          rb_dataB,
    output logic [31:0]          snap_dataA,
    output logic [31:0]          snap_dataB,
    output logic [31:0]          snap_addr,
    output logic [SEQ_WIDTH-1:0] snap_seq,
    output logic                 snap_valid,
    output logic [31:0]          snap_age,
    output logic                 ps_ack_toggle,
    output logic [7:0]           overrun_cnt,
    output logic                 busy
);

    localparam int unsigned CNT_W    = 4;
    localparam logic [31:0] AGE_MAX  = 32'hFFFF_FFFF;
    localparam logic [7:0]  OVR_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             req_seen;
    logic             req_seen_nxt;
    logic             req_prev;
    logic             start_c;
    logic             capture_c;

    // FSM state register and request bookkeeping
    always_ff @(posedge aclk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            req_seen <= 1'b0;
            req_prev <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            req_seen <= req_seen_nxt;
            req_prev <= ps_req_toggle;
        end
    end

    // Next-state decode: requests are only compared against req_seen while idle
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        req_seen_nxt = req_seen;
        start_c      = 1'b0;
        capture_c    = 1'b0;
        case (state)
            IDLE: begin
                if (ps_req_toggle != req_seen) begin
                    start_c      = 1'b1;
                    req_seen_nxt = ps_req_toggle;
                    cnt_nxt      = CNT_W'(SETTLE_CYCLES);
                    state_nxt    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            CAPTURE: begin
                capture_c = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs: mux address, snapshot, ack, age, overrun and busy
    always_ff @(posedge aclk) begin
        if (reset) begin
            rb_config_addr <= DEFAULT_ADDR;
            snap_dataA     <= '0;
            snap_dataB     <= '0;
            snap_addr      <= '0;
            snap_seq       <= '0;
            snap_valid     <= 1'b0;
            snap_age       <= '0;
            ps_ack_toggle  <= 1'b0;
            overrun_cnt    <= '0;
            busy           <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (start_c) begin
                rb_config_addr <= ps_config_addr;
            end
            if ((state != IDLE) && (ps_req_toggle != req_prev) && (overrun_cnt != OVR_MAX)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (capture_c) begin
                snap_dataA    <= rb_dataA;
                snap_dataB    <= rb_dataB;
                snap_addr     <= rb_config_addr;
                snap_seq      <= snap_seq + SEQ_WIDTH'(1);
                snap_valid    <= 1'b1;
                snap_age      <= '0;
                ps_ack_toggle <= req_seen;
            end else if (snap_valid && (snap_age != AGE_MAX)) begin
                snap_age <= snap_age + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_readback_snapshot_ctrl.sv
// Bench for readback_snapshot_ctrl: directed scenarios plus randomized traffic
// checked against a per-edge countdown model of the request/capture rules.
module tb_readback_snapshot_ctrl;

    localparam logic [31:0] DEF = 32'd100001;

    logic        aclk = 1'b0;
    logic        reset;
    logic [31:0] addr0, addr1, da, db;
    logic        tog0, tog1;

    logic [31:0] rb0, sa0, sb0, saddr0, age0;
    logic [15:0] seq0;
    logic        valid0, ack0, busy0;
    logic [7:0]  ovr0;

    logic [31:0] rb1, sa1, sb1, saddr1, age1;
    logic [3:0]  seq1;
    logic        valid1, ack1, busy1;
    logic [7:0]  ovr1;

    int n_run  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    readback_snapshot_ctrl dut0 (
        .aclk(aclk), .reset(reset), .ps_config_addr(addr0), .ps_req_toggle(tog0),
        .rb_config_addr(rb0), .rb_dataA(da), .rb_dataB(db),
        .snap_dataA(sa0), .snap_dataB(sb0), .snap_addr(saddr0), .snap_seq(seq0),
        .snap_valid(valid0), .snap_age(age0), .ps_ack_toggle(ack0),
        .overrun_cnt(ovr0), .busy(busy0)
    );

    readback_snapshot_ctrl #(.SETTLE_CYCLES(1), .SEQ_WIDTH(4)) dut1 (
        .aclk(aclk), .reset(reset), .ps_config_addr(addr1), .ps_req_toggle(tog1),
        .rb_config_addr(rb1), .rb_dataA(da), .rb_dataB(db),
        .snap_dataA(sa1), .snap_dataB(sb1), .snap_addr(saddr1), .snap_seq(seq1),
        .snap_valid(valid1), .snap_age(age1), .ps_ack_toggle(ack1),
        .overrun_cnt(ovr1), .busy(busy1)
    );

    // Reference: "left" counts remaining busy edges; the capture happens on the last one
    typedef struct {
        logic [31:0] rb, sa, sb, saddr, age;
        logic [15:0] seq;
        logic        valid, ack, seen, prev, busy;
        logic [7:0]  ovr;
        int          left;
    } model_t;

    model_t m0, m1;

    function automatic model_t mstep(model_t m, logic rst, logic tog, logic [31:0] addr,
                                     logic [31:0] a, logic [31:0] b, int s, int sw);
        model_t n;
        n = m;
        if (rst) begin
            n.rb = DEF; n.sa = 0; n.sb = 0; n.saddr = 0; n.age = 0; n.seq = 0;
            n.valid = 0; n.ack = 0; n.seen = 0; n.prev = 0; n.busy = 0; n.ovr = 0; n.left = 0;
            return n;
        end
        n.prev = tog;
        if (m.left == 0) begin
            if (tog != m.seen) begin
                n.rb = addr; n.seen = tog; n.left = s + 1;
            end
            if (m.valid && m.age != 32'hFFFF_FFFF) n.age = m.age + 32'd1;
        end else begin
            if (tog != m.prev && m.ovr != 8'd255) n.ovr = m.ovr + 8'd1;
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.sa = a; n.sb = b; n.saddr = m.rb; n.valid = 1; n.age = 0; n.ack = m.seen;
                n.seq = 16'((32'(m.seq) + 1) % (1 << sw));
            end else if (m.valid && m.age != 32'hFFFF_FFFF) begin
                n.age = m.age + 32'd1;
            end
        end
        n.busy = (n.left > 0);
        return n;
    endfunction

    // Advance both models on every active edge with the inputs the DUTs see
    always @(posedge aclk) begin
        m0 = mstep(m0, reset, tog0, addr0, da, db, 2, 16);
        m1 = mstep(m1, reset, tog1, addr1, da, db, 1, 4);
    end

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic test_reset();
        reset = 1; tog0 = 0; tog1 = 0; addr0 = 0; addr1 = 0; da = 0; db = 0;
        tick(); tick();
        reset = 0;
        repeat (10) tick();
        n_run++; if (rb0 !== DEF) begin n_fail++; $display("FAIL reset_rb_addr got %0d want %0d", rb0, DEF); end
        n_run++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid0); end
        n_run++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack0); end
        n_run++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy0); end
        n_run++; if (age0 !== 32'd0) begin n_fail++; $display("FAIL reset_age got %0d want 0", age0); end
        n_run++; if (seq0 !== 16'd0 || ovr0 !== 8'd0) begin n_fail++; $display("FAIL reset_seq_ovr got %0d/%0d want 0/0", seq0, ovr0); end
    endtask

    task automatic test_single();
        addr0 = 32'd100002; da = 32'hA5A5_0001; db = 32'h5A5A_0002;
        tog0 = 1;
        tick();
        n_run++; if (ack0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL single_t0 got ack=%b busy=%b want 0/1", ack0, busy0); end
        tick();
        n_run++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL single_t1_ack got %b want 0", ack0); end
        tick();
        n_run++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL single_t2_ack got %b want 0", ack0); end
        tick();
        n_run++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL single_t3_ack got %b want 1", ack0); end
        n_run++; if (sa0 !== 32'hA5A5_0001 || sb0 !== 32'h5A5A_0002) begin n_fail++; $display("FAIL single_data got %h/%h want a5a50001/5a5a0002", sa0, sb0); end
        n_run++; if (saddr0 !== 32'd100002) begin n_fail++; $display("FAIL single_addr got %0d want 100002", saddr0); end
        n_run++; if (seq0 !== 16'd1 || valid0 !== 1'b1) begin n_fail++; $display("FAIL single_seq_valid got %0d/%b want 1/1", seq0, valid0); end
        n_run++; if (age0 !== 32'd0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL single_age_busy got %0d/%b want 0/0", age0, busy0); end
        tick();
        n_run++; if (age0 !== 32'd1) begin n_fail++; $display("FAIL single_age_count got %0d want 1", age0); end
    endtask

    task automatic test_addr_hold();
        addr0 = 32'h1234_5678;
        tog0 = ~tog0;
        tick();
        addr0 = 32'hDEAD_BEEF;
        repeat (4) tick();
        n_run++; if (saddr0 !== 32'h1234_5678) begin n_fail++; $display("FAIL hold_snap_addr got %h want 12345678", saddr0); end
        n_run++; if (rb0 !== 32'h1234_5678) begin n_fail++; $display("FAIL hold_rb_addr got %h want 12345678", rb0); end
    endtask

    task automatic test_overrun();
        logic [7:0]  o;
        logic [15:0] s;
        o = ovr0; s = seq0;
        tog0 = ~tog0; tick();
        tog0 = ~tog0; tick();
        tog0 = ~tog0; tick();
        repeat (6) tick();
        n_run++; if (ovr0 !== 8'(o + 8'd2)) begin n_fail++; $display("FAIL overrun_even_cnt got %0d want %0d", ovr0, 8'(o + 8'd2)); end
        n_run++; if (seq0 !== 16'(s + 16'd1) || busy0 !== 1'b0) begin n_fail++; $display("FAIL overrun_even_seq got %0d/%b want %0d/0", seq0, busy0, 16'(s + 16'd1)); end
        o = ovr0; s = seq0;
        tog0 = ~tog0; tick();
        repeat (3) begin tog0 = ~tog0; tick(); end
        repeat (8) tick();
        n_run++; if (ovr0 !== 8'(o + 8'd3)) begin n_fail++; $display("FAIL overrun_odd_cnt got %0d want %0d", ovr0, 8'(o + 8'd3)); end
        n_run++; if (seq0 !== 16'(s + 16'd2) || ack0 !== tog0) begin n_fail++; $display("FAIL overrun_odd_seq got %0d/%b want %0d/%b", seq0, ack0, 16'(s + 16'd2), tog0); end
    endtask

    task automatic test_reset_abort();
        if (tog0) begin tog0 = 0; repeat (5) tick(); end
        tog0 = 1;
        tick(); tick();
        reset = 1;
        tick();
        n_run++; if (ack0 !== 1'b0 || seq0 !== 16'd0 || valid0 !== 1'b0) begin n_fail++; $display("FAIL abort_ack_seq got %b/%0d/%b want 0/0/0", ack0, seq0, valid0); end
        n_run++; if (rb0 !== DEF || busy0 !== 1'b0 || ovr0 !== 8'd0) begin n_fail++; $display("FAIL abort_regs got %0d/%b/%0d want %0d/0/0", rb0, busy0, ovr0, DEF); end
        n_run++; if (sa0 !== 0 || sb0 !== 0 || saddr0 !== 0 || age0 !== 0) begin n_fail++; $display("FAIL abort_snap got %h/%h/%h/%0d want zeros", sa0, sb0, saddr0, age0); end
        reset = 0;
        tick();
        n_run++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL pending_busy got %b want 1", busy0); end
        tick(); tick(); tick();
        n_run++; if (ack0 !== 1'b1 || seq0 !== 16'd1) begin n_fail++; $display("FAIL pending_ack got %b/%0d want 1/1", ack0, seq0); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) tog0 = ~tog0;
            if ($urandom_range(2) == 0) tog1 = ~tog1;
            addr0 = $urandom; addr1 = $urandom; da = $urandom; db = $urandom;
            tick();
            n_run++;
            if (rb0 !== m0.rb || sa0 !== m0.sa || sb0 !== m0.sb || saddr0 !== m0.saddr ||
                seq0 !== m0.seq || valid0 !== m0.valid || age0 !== m0.age || ack0 !== m0.ack ||
                ovr0 !== m0.ovr || busy0 !== m0.busy) begin
                n_fail++;
                if (bad < 5) $display("FAIL random_dut0 cyc %0d got ack=%b seq=%0d ovr=%0d age=%0d busy=%b want ack=%b seq=%0d ovr=%0d age=%0d busy=%b",
                    i, ack0, seq0, ovr0, age0, busy0, m0.ack, m0.seq, m0.ovr, m0.age, m0.busy);
                bad++;
            end
            n_run++;
            if (rb1 !== m1.rb || sa1 !== m1.sa || saddr1 !== m1.saddr || seq1 !== m1.seq[3:0] ||
                ack1 !== m1.ack || ovr1 !== m1.ovr || busy1 !== m1.busy || age1 !== m1.age) begin
                n_fail++;
                if (bad < 5) $display("FAIL random_dut1 cyc %0d got ack=%b seq=%0d ovr=%0d busy=%b want ack=%b seq=%0d ovr=%0d busy=%b",
                    i, ack1, seq1, ovr1, busy1, m1.ack, m1.seq, m1.ovr, m1.busy);
                bad++;
            end
        end
        repeat (6) tick();
    endtask

    task automatic test_wrap();
        logic prev;
        tog0 = 0; tog1 = 0;
        reset = 1; tick(); reset = 0; tick();
        for (int i = 0; i < 17; i++) begin
            prev = ack1;
            tog1 = ~tog1;
            tick();
            n_run++; if (ack1 !== prev) begin n_fail++; $display("FAIL wrap_ack_early req %0d got %b want %b", i, ack1, prev); end
            tick();
            n_run++; if (ack1 !== prev) begin n_fail++; $display("FAIL wrap_ack_t1 req %0d got %b want %b", i, ack1, prev); end
            tick();
            n_run++; if (ack1 !== tog1) begin n_fail++; $display("FAIL wrap_ack_t2 req %0d got %b want %b", i, ack1, tog1); end
            if (i == 15) begin
                n_run++; if (seq1 !== 4'd0 || valid1 !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got %0d/%b want 0/1", seq1, valid1); end
            end
        end
        n_run++; if (seq1 !== 4'd1 || valid1 !== 1'b1) begin n_fail++; $display("FAIL wrap_one got %0d/%b want 1/1", seq1, valid1); end
    endtask

    task test_age_sat;
        tog0 = ~tog0;
        repeat (5) tick();
        force dut0.snap_age = 32'hFFFF_FFFD;
        m0.age = 32'hFFFF_FFFD;
        #1;
        release dut0.snap_age;
        tick();
        n_run++; if (age0 !== 32'hFFFF_FFFE || m0.age !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL age_step got %h (model %h) want fffffffe", age0, m0.age); end
        tick();
        n_run++; if (age0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL age_max got %h want ffffffff", age0); end
        repeat (3) tick();
        n_run++; if (age0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL age_sat got %h want ffffffff", age0); end
        tog0 = ~tog0;
        repeat (4) tick();
        n_run++; if (age0 !== 32'd0 || ack0 !== tog0) begin n_fail++; $display("FAIL age_clear got %0d/%b want 0/%b", age0, ack0, tog0); end
    endtask

    initial begin
        reset = 1; tog0 = 0; tog1 = 0; addr0 = 0; addr1 = 0; da = 0; db = 0;
        @(negedge aclk);
        test_reset();
        test_single();
        test_addr_hold();
        test_overrun();
        test_reset_abort();
        test_random();
        test_wrap();
        test_age_sat();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
